// File: rtl/act_pkg.sv
// Shared defaults and FSM encoding for the activation burst reader.
package act_pkg;

  localparam int ACT_DWIDTH   = 12;
  localparam int ACT_AWIDTH   = 10;
  localparam int ACT_MEM_SIZE = 384;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/act_skid_fifo.sv
// Two-entry in-order buffer holding RAM read results (data plus last flag).
module act_skid_fifo #(
  parameter int WIDTH = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             valid,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             pop_ok;

  assign valid     = (count != 2'd0);
  assign pop_ok    = pop & valid;
  assign head_data = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the two entries are reset on purpose so the streamed word reads
      // as zero out of reset; larger memories would normally be left unreset.
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop_ok);
    end
  end

endmodule

// File: rtl/act_data_reader.sv
// Burst reader: issues wrapped RAM reads with credit flow control and streams words out.
module act_data_reader
  import act_pkg::*;
#(
  parameter int DWIDTH   = ACT_DWIDTH,
  parameter int AWIDTH   = ACT_AWIDTH,
  parameter int MEM_SIZE = ACT_MEM_SIZE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [AWIDTH-1:0] base_addr,
  input  logic [AWIDTH-1:0] length,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [AWIDTH-1:0] ram_addr,
  output logic              ram_ce,
  output logic              ram_we,
  input  logic [DWIDTH-1:0] ram_q,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(MEM_SIZE - 1);

  state_e            state;
  logic [AWIDTH-1:0] cur_addr;
  logic [AWIDTH-1:0] remaining;
  logic              inflight;
  logic              inflight_last;
  logic              fifo_valid;
  logic [1:0]        fifo_count;
  logic [DWIDTH:0]   head;
  logic              pop;
  logic              issue;
  logic [2:0]        pending;

  // Buffered + in-flight words, less the one leaving this cycle, must stay below two.
  assign pop     = out_valid & out_ready;
  assign pending = 3'(fifo_count) + 3'(inflight) - 3'(pop);
  assign issue   = (state == ST_READ) && (pending < 3'd2);

  assign ram_ce    = issue;
  assign ram_addr  = cur_addr;
  assign ram_we    = 1'b0;
  assign out_valid = fifo_valid;
  assign out_data  = head[DWIDTH-1:0];
  assign out_last  = fifo_valid & head[DWIDTH];

  act_skid_fifo #(
    .WIDTH (DWIDTH + 1)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data ({inflight_last, ram_q}),
    .pop       (pop),
    .head_data (head),
    .valid     (fifo_valid),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      cur_addr      <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      done          <= 1'b0;
      err           <= 1'b0;
      inflight      <= issue;
      inflight_last <= issue && (remaining == AWIDTH'(1));
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (base_addr > LAST_ADDR) begin
              err <= 1'b1;
            end else if (length == '0) begin
              done <= 1'b1;
            end else begin
              state     <= ST_READ;
              busy      <= 1'b1;
              cur_addr  <= base_addr;
              remaining <= length;
            end
          end
        end
        ST_READ: begin
          if (issue) begin
            cur_addr  <= (cur_addr == LAST_ADDR) ? '0 : cur_addr + AWIDTH'(1);
            remaining <= remaining - AWIDTH'(1);
            if (remaining == AWIDTH'(1)) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (pop && out_last) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_act_data_reader.sv
// Directed self-checking bench for act_data_reader with a one-cycle-latency RAM model.
module tb_act_data_reader;

  localparam int DW  = 12;
  localparam int AW  = 10;
  localparam int MEM = 384;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] length = '0;
  logic          busy, done, err;
  logic [AW-1:0] ram_addr;
  logic          ram_ce, ram_we;
  logic [DW-1:0] ram_q = '0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_last;

  logic [DW-1:0] ram_mem [MEM];

  int n_checks = 0;
  int n_pass   = 0;

  logic [AW-1:0] addr_q [$];
  logic [DW-1:0] data_q [$];
  logic          last_q [$];
  int ce_cnt = 0, xfer_cnt = 0, done_cnt = 0, err_cnt = 0, max_out = 0;
  bit prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic prev_last = 1'b0;

  act_data_reader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .ram_addr  (ram_addr),
    .ram_ce    (ram_ce),
    .ram_we    (ram_we),
    .ram_q     (ram_q),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_ce) ram_q <= ram_mem[ram_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Observe the interface mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall)
        check("stall_hold", {out_valid, out_last, out_data}, {1'b1, prev_last, prev_data});
      if (ram_ce) begin
        addr_q.push_back(ram_addr);
        ce_cnt++;
      end
      if (out_valid && out_ready) begin
        data_q.push_back(out_data);
        last_q.push_back(out_last);
        xfer_cnt++;
      end
      if (ce_cnt - xfer_cnt > max_out) max_out = ce_cnt - xfer_cnt;
      if (done) done_cnt++;
      if (err) err_cnt++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic clear_log();
    addr_q.delete();
    data_q.delete();
    last_q.delete();
    ce_cnt   = 0;
    xfer_cnt = 0;
    max_out  = 0;
  endtask

  task automatic start_burst(input logic [AW-1:0] b, input logic [AW-1:0] l);
    base_addr = b;
    length    = l;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, input bit toggle);
    int d0 = done_cnt;
    int i  = 0;
    while (done_cnt == d0 && i < budget) begin
      @(posedge clk); #1;
      if (toggle) out_ready = ~out_ready;
      i++;
    end
    check({tag, "_done_seen"}, 32'(done_cnt != d0), 32'd1);
    out_ready = 1'b1;
  endtask

  task automatic check_burst(input string tag, input int b, input int l);
    check({tag, "_nwords"}, data_q.size(), l);
    check({tag, "_nreads"}, addr_q.size(), l);
    for (int i = 0; i < l; i++) begin
      int a = (b + i) % MEM;
      if (i < data_q.size()) begin
        check($sformatf("%s_data%0d", tag, i), data_q[i], a + 'h100);
        check($sformatf("%s_last%0d", tag, i), last_q[i], 32'(i == l - 1));
      end
      if (i < addr_q.size()) check($sformatf("%s_addr%0d", tag, i), addr_q[i], a);
    end
    check({tag, "_max_outstanding_le2"}, 32'(max_out <= 2), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int d0;
    for (int i = 0; i < MEM; i++) ram_mem[i] = DW'(i + 'h100);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_ce", ram_ce, 0);
    check("rst_we", ram_we, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_addr", ram_addr, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Base 0, length 4, ready high: cycle-exact streaming
    clear_log();
    start_burst(0, 4);
    check("t1_busy", busy, 1);
    check("t1_v0", out_valid, 0);
    @(posedge clk); #1;
    check("t1_v1", out_valid, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check($sformatf("t1_valid%0d", i), out_valid, 1);
      check($sformatf("t1_word%0d", i), out_data, 'h100 + i);
      check($sformatf("t1_lastflag%0d", i), out_last, 32'(i == 3));
      check($sformatf("t1_nodone%0d", i), done, 0);
    end
    @(posedge clk); #1;
    check("t1_done", done, 1);
    check("t1_busy_end", busy, 0);
    check("t1_valid_end", out_valid, 0);
    @(posedge clk); #1;
    check("t1_done_pulse", done, 0);
    check_burst("t1", 0, 4);

    // Wrap from the top of memory
    clear_log();
    start_burst(382, 4);
    wait_done("t2", 50, 1'b0);
    check_burst("t2", 382, 4);

    // Backpressure with ready toggling
    clear_log();
    out_ready = 1'b1;
    start_burst(10, 6);
    wait_done("t3", 100, 1'b1);
    check_burst("t3", 10, 6);

    // Zero length and out-of-range base
    clear_log();
    d0 = done_cnt;
    start_burst(5, 0);
    check("t4_done", done, 1);
    check("t4_busy", busy, 0);
    @(posedge clk); #1;
    check("t4_done_pulse", done, 0);
    check("t4_done_cnt", done_cnt, d0 + 1);
    start_burst(400, 3);
    check("t4_err", err, 1);
    check("t4_err_busy", busy, 0);
    @(posedge clk); #1;
    check("t4_err_pulse", err, 0);
    check("t4_err_busy2", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    check("t4_no_reads", ce_cnt, 0);
    check("t4_err_cnt", err_cnt, 1);

    // Reset after three of eight words
    clear_log();
    start_burst(20, 8);
    for (int i = 0; i < 50 && xfer_cnt < 3; i++) begin
      @(posedge clk); #1;
    end
    check("t5_three_words", xfer_cnt, 3);
    out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_err", err, 0);
    check("t5_ce", ram_ce, 0);
    check("t5_valid", out_valid, 0);
    check("t5_last", out_last, 0);
    check("t5_data", out_data, 0);
    check("t5_addr", ram_addr, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    clear_log();
    start_burst(50, 2);
    wait_done("t5b", 50, 1'b0);
    check_burst("t5b", 50, 2);

    // Start while busy is ignored
    clear_log();
    start_burst(100, 5);
    @(posedge clk); #1;
    start_burst(200, 2);
    d0 = done_cnt;
    wait_done("t6", 50, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    check("t6_single_done", done_cnt, d0 + 1);
    check("t6_busy", busy, 0);
    check_burst("t6", 100, 5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/act_data_reader.md
ACT_DATA_READER -- requirements
Module: act_data_reader

Interface
REQ-001 SHALL have parameter DWIDTH, default 12, activation word width.
REQ-002 SHALL have parameter AWIDTH, default 10, RAM address width.
REQ-003 SHALL have parameter MEM_SIZE, default 384, RAM depth in words.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a burst read.
REQ-007 SHALL have port base_addr  input  AWIDTH  first word address; sampled with start.
REQ-008 SHALL have port length  input  AWIDTH  word count; sampled with start.
REQ-009 SHALL have port busy  output  1  high from accepted start until done.
REQ-010 SHALL have port done  output  1  one-cycle pulse at burst completion.
REQ-011 SHALL have port err  output  1  one-cycle pulse when start is rejected for bad base_addr.
REQ-012 SHALL have port ram_addr  output  AWIDTH  address to activation RAM.
REQ-013 SHALL have port ram_ce  output  1  RAM chip enable, high only when a read is issued.
REQ-014 SHALL have port ram_we  output  1  RAM write enable, constant 0.
REQ-015 SHALL have port ram_q  input  DWIDTH  RAM read data, valid one cycle after ram_ce.
REQ-016 SHALL have port out_data  output  DWIDTH  streamed activation word.
REQ-017 SHALL have port out_valid  output  1  out_data valid.
REQ-018 SHALL have port out_ready  input  1  downstream accepts; transfer when valid and ready.
REQ-019 SHALL have port out_last  output  1  marks final word of burst, qualified by out_valid.

Function
REQ-020 SHALL implement FSM IDLE -> READ (start accepted, length>0) -> DRAIN (all reads issued) -> IDLE (last transfer done).
REQ-021 SHALL accept start only in IDLE; start while busy SHALL be ignored without effect.
REQ-022 SHALL, on start with base_addr >= MEM_SIZE, stay IDLE and pulse err next cycle.
REQ-023 SHALL, on start with length==0 and valid base_addr, stay IDLE and pulse done next cycle; no RAM access.
REQ-024 SHALL issue read i at address (base_addr+i) modulo MEM_SIZE, wrapping MEM_SIZE-1 -> 0.
REQ-025 SHALL hold results in a 2-entry in-order buffer; issue a read only when occupancy + in-flight - (out_valid & out_ready) < 2.
REQ-026 SHALL sustain one word per cycle when out_ready held high; first out_valid 2 cycles after start.
REQ-027 SHALL capture ram_q exactly one cycle after each issued ram_ce into the buffer tail.
REQ-028 SHALL keep out_data and out_last stable while out_valid high and out_ready low.
REQ-029 SHALL assert out_last only with the length-th word; SHALL pulse done the cycle after its transfer and deassert busy same cycle.
REQ-030 SHALL drive ram_ce low in IDLE and DRAIN; ram_addr value don't-care when ram_ce low.

Reset
REQ-031 SHALL on rst force IDLE, busy=0, done=0, err=0, ram_ce=0, out_valid=0, out_last=0, out_data=0, ram_addr=0.
REQ-032 SHALL on rst mid-burst empty the buffer and discard any in-flight read; next start begins clean.

Structure
REQ-033 SHALL take DWIDTH, AWIDTH, MEM_SIZE defaults and the FSM state encoding from shared package act_pkg.
REQ-034 SHALL instantiate one sub-module act_skid_fifo (2-entry, DWIDTH+1 bits incl. last flag).

Verification
REQ-035 Base 0, length 4, RAM[i]=i+0x100, ready=1 -> 0x100..0x103 on consecutive cycles, last on 0x103, done next cycle.
REQ-036 Base 382, length 4 -> reads addr 382,383,0,1 in that order.
REQ-037 Length 6, ready toggling 1/0 -> no lost/duplicated words, data stable while stalled, never >2 reads outstanding.
REQ-038 Length 0 -> done pulse next cycle, ram_ce never high; base 400 -> err pulse, busy stays 0.
REQ-039 rst asserted after 3 of 8 words -> all outputs at reset values next cycle; new burst length 2 returns correct 2 words.
REQ-040 start reasserted while busy -> ignored; original burst completes unchanged.
